// File: rtl/sync_multi_queue.sv
// sync_multi_queue: multi-lane-write, single-lane-read synchronous queue.
// Up to WRITE_WIDTH entries enter per clock and are compacted in lane order.
// One entry leaves per clock. Depth may be any integer >= 2, and the
// pointers wrap explicitly.
module sync_multi_queue #(
  parameter int DATA_SIZE   = 32,
  parameter int QUEUE_SIZE  = 16,
  parameter int WRITE_WIDTH = 2,
  parameter int SLACK       = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                kill,
  output logic                                wready,
  input  logic [WRITE_WIDTH-1:0]              wvalid,
  input  logic [WRITE_WIDTH*DATA_SIZE-1:0]    wdata,
  input  logic                                rready,
  output logic                                rvalid,
  output logic [DATA_SIZE-1:0]                rdata,
  output logic [$clog2(QUEUE_SIZE+1)-1:0]     count
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = $clog2(QUEUE_SIZE + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int NEED  = WRITE_WIDTH + SLACK;
  localparam logic [CNT_W-1:0] QSIZE_C = CNT_W'(QUEUE_SIZE);
  localparam logic [SUM_W-1:0] QSIZE_S = SUM_W'(QUEUE_SIZE);

  // Advance a pointer by inc (inc <= QUEUE_SIZE) and wrap at QUEUE_SIZE.
  // One subtraction is enough because ptr + inc < 2*QUEUE_SIZE.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [CNT_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(ptr) + SUM_W'(inc);
    if (sum >= QSIZE_S) begin
      sum = sum - QSIZE_S;
    end
    return sum[PTR_W-1:0];
  endfunction

  // Number of asserted write lanes.
  function automatic logic [CNT_W-1:0] popcount(input logic [WRITE_WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WRITE_WIDTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  logic [DATA_SIZE-1:0] mem_q [QUEUE_SIZE];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic [CNT_W-1:0]     free_w;
  logic [CNT_W-1:0]     nwr_w;
  logic                 wr_acc_w;
  logic                 wr_en_w;
  logic                 rd_fire_w;
  logic [PTR_W-1:0]     lane_addr_w [WRITE_WIDTH];

  // Acceptance uses only pre-edge occupancy, so a same-cycle read never
  // makes room for a write in that cycle.
  always_comb begin
    free_w    = QSIZE_C - count_q;
    nwr_w     = popcount(wvalid);
    wr_acc_w  = (nwr_w != '0) && (nwr_w <= free_w);
    wr_en_w   = wr_acc_w && !kill;
    rd_fire_w = rready && (count_q != '0);
  end

  // Slot for each lane: valid lanes pack densely from tail, and invalid
  // lanes take no slot.
  always_comb begin
    logic [CNT_W-1:0] off;
    off = '0;
    for (int i = 0; i < WRITE_WIDTH; i++) begin
      lane_addr_w[i] = ptr_add(tail_q, off);
      off            = off + CNT_W'(wvalid[i]);
    end
  end

  // Next-state for pointers and occupancy. A kill drops everything stored
  // and also this cycle's write and read.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (kill) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (wr_acc_w) begin
        tail_d = ptr_add(tail_q, nwr_w);
      end
      if (rd_fire_w) begin
        head_d = ptr_add(head_q, CNT_W'(1));
      end
      count_d = count_q + (wr_acc_w ? nwr_w : '0) - CNT_W'(rd_fire_w);
    end
  end

  // Control state. Reset takes priority over kill, writes and reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write. No reset is needed because contents are qualified by
  // count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WRITE_WIDTH; i++) begin
      if (wr_en_w && wvalid[i]) begin
        mem_q[lane_addr_w[i]] <= wdata[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // Outputs are driven from registered state. There is no fall-through
  // from the write port.
  always_comb begin
    rvalid = (count_q != '0);
    rdata  = mem_q[head_q];
    count  = count_q;
    wready = (int'(free_w) >= NEED);
  end

endmodule

// File: tb/tb_sync_multi_queue.sv
// Directed bench for sync_multi_queue: a default 16-deep instance and a
// 5-deep, zero-slack instance that exercises wrap-around.
module tb_sync_multi_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // 16-entry instance (WRITE_WIDTH=2, SLACK=1)
  logic        b_kill, b_wready, b_rready, b_rvalid;
  logic [1:0]  b_wvalid;
  logic [63:0] b_wdata;
  logic [31:0] b_rdata;
  logic [4:0]  b_count;

  // 5-entry instance (WRITE_WIDTH=2, SLACK=0)
  logic        s_kill, s_wready, s_rready, s_rvalid;
  logic [1:0]  s_wvalid;
  logic [63:0] s_wdata;
  logic [31:0] s_rdata;
  logic [2:0]  s_count;

  sync_multi_queue #(.DATA_SIZE(32), .QUEUE_SIZE(16), .WRITE_WIDTH(2), .SLACK(1)) u_big (
    .clk(clk), .reset(reset), .kill(b_kill), .wready(b_wready), .wvalid(b_wvalid),
    .wdata(b_wdata), .rready(b_rready), .rvalid(b_rvalid), .rdata(b_rdata), .count(b_count)
  );

  sync_multi_queue #(.DATA_SIZE(32), .QUEUE_SIZE(5), .WRITE_WIDTH(2), .SLACK(0)) u_small (
    .clk(clk), .reset(reset), .kill(s_kill), .wready(s_wready), .wvalid(s_wvalid),
    .wdata(s_wdata), .rready(s_rready), .rvalid(s_rvalid), .rdata(s_rdata), .count(s_count)
  );

  int n_app = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_app++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occupancy must stay within depth at all times.
  always @(negedge clk) begin
    if (!reset && (b_count > 5'd16 || s_count > 3'd5)) begin
      n_mis++;
      $display("FAIL count_bound: big %0d small %0d", b_count, s_count);
    end
  end

  typedef struct {
    logic        kill;
    logic [1:0]  wvalid;
    logic [31:0] d0, d1;
    logic        rready;
    logic        e_rvalid;
    logic [31:0] e_rdata;
    logic [4:0]  e_count;
    logic        e_wready;
  } vec_t;

  vec_t vt[14];
  logic [31:0] sq[$];

  initial begin
    // Tests 1 (basic), 2 (compaction), 5 (kill with write and read)
    vt[0]  = '{1'b0, 2'b11, 32'hA0A0_0001, 32'hB0B0_0002, 1'b0, 1'b1, 32'hA0A0_0001, 5'd2, 1'b1};
    vt[1]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'hB0B0_0002, 5'd1, 1'b1};
    vt[2]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         5'd0, 1'b1};
    vt[3]  = '{1'b0, 2'b10, 32'hDEAD_0000, 32'hC0C0_0003, 1'b0, 1'b1, 32'hC0C0_0003, 5'd1, 1'b1};
    vt[4]  = '{1'b0, 2'b01, 32'hD0D0_0004, 32'hDEAD_0001, 1'b0, 1'b1, 32'hC0C0_0003, 5'd2, 1'b1};
    vt[5]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'hD0D0_0004, 5'd1, 1'b1};
    vt[6]  = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         5'd0, 1'b1};
    vt[7]  = '{1'b0, 2'b11, 32'h5100_0001, 32'h5100_0002, 1'b0, 1'b1, 32'h5100_0001, 5'd2, 1'b1};
    vt[8]  = '{1'b0, 2'b01, 32'h5100_0003, 32'h0,         1'b0, 1'b1, 32'h5100_0001, 5'd3, 1'b1};
    vt[9]  = '{1'b1, 2'b11, 32'h2222_0001, 32'h2222_0002, 1'b1, 1'b0, 32'h0,         5'd0, 1'b1};
    vt[10] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0,         5'd0, 1'b1};
    vt[11] = '{1'b0, 2'b11, 32'hE0E0_0001, 32'hE0E0_0002, 1'b0, 1'b1, 32'hE0E0_0001, 5'd2, 1'b1};
    vt[12] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b1, 32'hE0E0_0002, 5'd1, 1'b1};
    vt[13] = '{1'b0, 2'b00, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         5'd0, 1'b1};

    reset = 1'b1;
    b_kill = 1'b0; b_wvalid = 2'b00; b_wdata = '0; b_rready = 1'b0;
    s_kill = 1'b0; s_wvalid = 2'b00; s_wdata = '0; s_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset_b_count",  32'(b_count),  32'd0);
    chk("reset_b_rvalid", 32'(b_rvalid), 32'd0);
    chk("reset_b_wready", 32'(b_wready), 32'd1);
    chk("reset_s_count",  32'(s_count),  32'd0);
    chk("reset_s_wready", 32'(s_wready), 32'd1);

    for (int v = 0; v < 14; v++) begin
      b_kill   = vt[v].kill;
      b_wvalid = vt[v].wvalid;
      b_wdata  = {vt[v].d1, vt[v].d0};
      b_rready = vt[v].rready;
      step();
      chk($sformatf("vec%0d_rvalid", v), 32'(b_rvalid), 32'(vt[v].e_rvalid));
      chk($sformatf("vec%0d_count", v),  32'(b_count),  32'(vt[v].e_count));
      chk($sformatf("vec%0d_wready", v), 32'(b_wready), 32'(vt[v].e_wready));
      if (vt[v].e_rvalid) chk($sformatf("vec%0d_rdata", v), b_rdata, vt[v].e_rdata);
    end
    b_kill = 1'b0; b_wvalid = 2'b00; b_rready = 1'b0;

    // Test 3: fill to 14, accept one more 2-lane write, refuse once full.
    for (int i = 0; i < 7; i++) begin
      b_wvalid = 2'b11;
      b_wdata  = {32'h300 + 32'(2*i+1), 32'h300 + 32'(2*i)};
      step();
    end
    b_wvalid = 2'b00;
    chk("fill14_count",  32'(b_count),  32'd14);
    chk("fill14_wready", 32'(b_wready), 32'd0);
    b_wvalid = 2'b11;
    b_wdata  = {32'h30F, 32'h30E};
    step();
    chk("fill16_count",  32'(b_count),  32'd16);
    chk("fill16_rvalid", 32'(b_rvalid), 32'd1);
    b_wvalid = 2'b01;
    b_wdata  = {32'h0, 32'hBAD0_0BAD};
    step();
    chk("full_refuse_count", 32'(b_count), 32'd16);
    b_wvalid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_rdata", i), b_rdata, 32'h300 + 32'(i));
      b_rready = 1'b1;
      step();
    end
    chk("drain_count",  32'(b_count),  32'd0);
    chk("drain_rvalid", 32'(b_rvalid), 32'd0);
    step();
    chk("empty_read_count", 32'(b_count), 32'd0);
    b_rready = 1'b0;

    // Test 4: random traffic on the 5-deep instance against a model.
    for (int c = 0; c < 20; c++) begin
      logic [1:0]  wv;
      logic [31:0] d0, d1;
      logic        rr, acc, rd;
      int          n, fr;
      wv = 2'($urandom_range(0, 3));
      d0 = $urandom;
      d1 = $urandom;
      rr = 1'($urandom_range(0, 1));
      s_wvalid = wv;
      s_wdata  = {d1, d0};
      s_rready = rr;
      fr  = 5 - sq.size();
      n   = int'(wv[0]) + int'(wv[1]);
      acc = (n != 0) && (n <= fr);
      rd  = rr && (sq.size() != 0);
      chk($sformatf("rnd%0d_rvalid", c), 32'(s_rvalid), 32'(sq.size() != 0));
      chk($sformatf("rnd%0d_wready", c), 32'(s_wready), 32'(fr >= 2));
      if (sq.size() != 0) chk($sformatf("rnd%0d_rdata", c), s_rdata, sq[0]);
      if (rd) void'(sq.pop_front());
      if (acc) begin
        if (wv[0]) sq.push_back(d0);
        if (wv[1]) sq.push_back(d1);
      end
      step();
      chk($sformatf("rnd%0d_count", c), 32'(s_count), 32'(sq.size()));
    end
    s_wvalid = 2'b00; s_rready = 1'b0;

    // Test 6: reset mid-stream overrides kill and writes.
    b_wvalid = 2'b11; b_wdata = {32'h601, 32'h600}; step();
    b_wvalid = 2'b11; b_wdata = {32'h603, 32'h602}; step();
    b_wvalid = 2'b00; b_rready = 1'b1; step();
    reset = 1'b1; b_kill = 1'b1; b_wvalid = 2'b11; b_wdata = {32'h6FF, 32'h6FE};
    step();
    reset = 1'b0; b_kill = 1'b0; b_wvalid = 2'b00; b_rready = 1'b0;
    chk("midrst_count",  32'(b_count),  32'd0);
    chk("midrst_rvalid", 32'(b_rvalid), 32'd0);
    chk("midrst_wready", 32'(b_wready), 32'd1);
    b_wvalid = 2'b11; b_wdata = {32'h611, 32'h610}; step();
    b_wvalid = 2'b00;
    chk("postrst_rdata0", b_rdata, 32'h610);
    chk("postrst_count",  32'(b_count), 32'd2);
    b_rready = 1'b1; step();
    chk("postrst_rdata1", b_rdata, 32'h611);
    step();
    b_rready = 1'b0;
    chk("postrst_rvalid", 32'(b_rvalid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_app, n_mis);
    $finish;
  end

endmodule
